// File: rtl/stepper_move_scheduler.sv
// Single-move stepper sequencer with a linear period ramp (accelerate, cruise, symmetric decelerate).
// Optional build macro SOFT_ABORT_EN: abort ramps the motor down instead of stopping at the next boundary.
module stepper_move_scheduler #(
    parameter int unsigned START_PERIOD = 1515151,
    parameter int unsigned RAMP_DEC     = 50000,
    parameter int unsigned PULSE_W      = 100,
    parameter int unsigned STEP_W       = 16
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic [31:0]       cmd_period,
    input  logic              abort,
    output logic              step_pulse,
    output logic              dir_out,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEL  = 3'd1,
        S_CRUISE = 3'd2,
        S_DECEL  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [31:0] START_P = 32'(START_PERIOD);
    localparam logic [31:0] RAMP    = 32'(RAMP_DEC);
    localparam logic [31:0] PW      = 32'(PULSE_W);
    localparam logic [31:0] MIN_P   = 32'(2 * PULSE_W);

    state_t            state_q, state_d;
    logic [31:0]       cur_q, cur_d, tgt_q, tgt_d, cnt_q, cnt_d;
    logic [STEP_W-1:0] left_q, left_d, acc_q, acc_d;
    logic              dir_q, dir_d;

    logic              moving, boundary;
    logic [STEP_W-1:0] left_nx, acc_dec;
    logic [31:0]       clamp_p, cur_up, cur_dn;
    logic [32:0]       up_sum, dn_lim;
`ifdef SOFT_ABORT_EN
    logic [STEP_W-1:0] abort_left;
    assign abort_left = (left_nx < acc_q) ? left_nx : acc_q;
`endif

    assign moving   = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);
    assign boundary = moving && (cnt_q == cur_q - 32'd1);
    assign left_nx  = left_q - 1'b1;
    assign acc_dec  = (acc_q == '0) ? '0 : acc_q - 1'b1;

    // Ramp arithmetic is done one bit wider so neither direction can wrap.
    assign up_sum = {1'b0, cur_q} + {1'b0, RAMP};
    assign cur_up = (up_sum >= {1'b0, START_P}) ? START_P : up_sum[31:0];
    assign dn_lim = {1'b0, tgt_q} + {1'b0, RAMP};
    assign cur_dn = ({1'b0, cur_q} > dn_lim) ? (cur_q - RAMP) : tgt_q;

    always_comb begin
        clamp_p = cmd_period;
        if (clamp_p < MIN_P)   clamp_p = MIN_P;
        if (clamp_p > START_P) clamp_p = START_P;
    end

    // Handshake: a command transfers on any clk edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, so a pending command simply waits while busy.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        acc_d   = acc_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_d  = cmd_dir;
                    left_d = cmd_steps;
                    tgt_d  = clamp_p;
                    cur_d  = START_P;
                    acc_d  = '0;
                    cnt_d  = '0;
                    if (cmd_steps == '0)         state_d = S_DONE;
                    else if (clamp_p == START_P) state_d = S_CRUISE;
                    else                         state_d = S_ACCEL;
                end
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                if (!boundary) begin
                    cnt_d = cnt_q + 32'd1;
                end else begin
                    cnt_d  = '0;
                    left_d = left_nx;
                    if (left_nx == '0) begin
                        state_d = S_DONE;
                    end else if (abort) begin
`ifdef SOFT_ABORT_EN
                        left_d = abort_left;
                        if (abort_left == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DECEL;
                            cur_d   = cur_up;
                            acc_d   = acc_dec;
                        end
`else
                        state_d = S_DONE;
`endif
                    end else if (left_nx <= acc_q) begin
                        // Remaining steps now match the steps spent accelerating.
                        state_d = S_DECEL;
                        cur_d   = cur_up;
                        acc_d   = acc_dec;
                    end else if (state_q == S_ACCEL) begin
                        cur_d = cur_dn;
                        acc_d = acc_q + 1'b1;
                        if (cur_dn == tgt_q) state_d = S_CRUISE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            left_q  <= '0;
            acc_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            acc_q   <= acc_d;
            dir_q   <= dir_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign step_pulse = moving && (cnt_q < PW);
    assign dir_out    = dir_q;
    assign busy       = moving;
    assign done       = (state_q == S_DONE);
    assign steps_left = left_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_stepper_move_scheduler.sv
// Bench for stepper_move_scheduler: step-level profile model versus observed pulse train.
// Build with +define+SOFT_ABORT_EN to exercise the ramp-down abort variant.
module tb_stepper_move_scheduler;

    localparam int SP  = 20;
    localparam int RD  = 4;
    localparam int PW  = 2;
    localparam int SW  = 16;
    localparam int MAX_CYC = 2000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCEL  = 3'd1;
    localparam logic [2:0] ST_CRUISE = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic          clk;
    logic          resetb;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [SW-1:0] cmd_steps;
    logic          cmd_dir;
    logic [31:0]   cmd_period;
    logic          abort;
    logic          step_pulse;
    logic          dir_out;
    logic          busy;
    logic          done;
    logic [SW-1:0] steps_left;
    logic [2:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    logic [31:0]   exp_period_q[$];
    logic [SW-1:0] exp_left_q[$];
    logic [SW-1:0] exp_final_left;
    logic [2:0]    exp_state0;

    stepper_move_scheduler #(
        .START_PERIOD(SP),
        .RAMP_DEC(RD),
        .PULSE_W(PW),
        .STEP_W(SW)
    ) dut (
        .clk(clk),
        .resetb(resetb),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps),
        .cmd_dir(cmd_dir),
        .cmd_period(cmd_period),
        .abort(abort),
        .step_pulse(step_pulse),
        .dir_out(dir_out),
        .busy(busy),
        .done(done),
        .steps_left(steps_left),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step-level profile: per-step period and steps_left seen as each step begins.
    task automatic model_move(input int n, input int raw, input int abort_at);
        int tgt, p, acc, left;
        bit ramp_down;
        exp_period_q.delete();
        exp_left_q.delete();
        tgt = (raw < 2 * PW) ? 2 * PW : raw;
        if (tgt > SP) tgt = SP;
        exp_state0 = (n == 0) ? ST_DONE : ((tgt == SP) ? ST_CRUISE : ST_ACCEL);
        p = SP; acc = 0; left = n; ramp_down = 0;
        for (int k = 1; k <= n; k++) begin
            exp_period_q.push_back(32'(p));
            exp_left_q.push_back(SW'(left));
            left = left - 1;
            if (left == 0) break;
            if (k == abort_at) begin
`ifdef SOFT_ABORT_EN
                left = (left < acc) ? left : acc;
                if (left == 0) break;
                ramp_down = 1;
                p = (p + RD > SP) ? SP : p + RD;
                acc = (acc > 0) ? acc - 1 : 0;
                continue;
`else
                break;
`endif
            end
            if (left <= acc) begin
                ramp_down = 1;
                p = (p + RD > SP) ? SP : p + RD;
                acc = (acc > 0) ? acc - 1 : 0;
            end else if (!ramp_down && p > tgt) begin
                p = (p - RD < tgt) ? tgt : p - RD;
                acc = acc + 1;
            end
        end
        exp_final_left = SW'(left);
    endtask

    // driver + monitor for one move
    task automatic run_move(input string name, input int n, input int raw, input bit d,
                            input int abort_at, input bit noise);
        int c, rises, last_rise, hi_len, done_c, total;
        bit prev;
        model_move(n, raw, abort_at);
        total = 0;
        foreach (exp_period_q[i]) total += int'(exp_period_q[i]);

        @(negedge clk);
        c = 0;
        while (!cmd_ready && c < MAX_CYC) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait got %b want 1", name, cmd_ready);
        end
        cmd_valid  = 1'b1;
        cmd_steps  = SW'(n);
        cmd_dir    = d;
        cmd_period = 32'(raw);
        @(negedge clk);
        cmd_valid = 1'b0;

        checks++;
        if (state_dbg !== exp_state0) begin
            errors++;
            $display("FAIL %s first_state got %0d want %0d", name, state_dbg, exp_state0);
        end

        prev = 0; rises = 0; last_rise = 0; hi_len = 0; done_c = -1; c = 0;
        while (done_c < 0 && c < MAX_CYC) begin
            if (done === 1'b1) begin
                done_c = c;
            end else begin
                checks++;
                if (busy !== 1'b1 || cmd_ready !== 1'b0 || dir_out !== d) begin
                    errors++;
                    $display("FAIL %s in_move c=%0d got busy=%b ready=%b dir=%b want 1 0 %b",
                             name, c, busy, cmd_ready, dir_out, d);
                end
            end
            if (step_pulse === 1'b1 && !prev) begin
                rises++;
                if (rises > 1 && rises - 2 < exp_period_q.size()) begin
                    checks++;
                    if (c - last_rise != int'(exp_period_q[rises-2])) begin
                        errors++;
                        $display("FAIL %s period step %0d got %0d want %0d",
                                 name, rises - 1, c - last_rise, exp_period_q[rises-2]);
                    end
                end
                checks++;
                if (rises - 1 >= exp_left_q.size()) begin
                    errors++;
                    $display("FAIL %s extra_step got %0d steps want %0d", name, rises, exp_left_q.size());
                end else if (steps_left !== exp_left_q[rises-1]) begin
                    errors++;
                    $display("FAIL %s steps_left step %0d got %0d want %0d",
                             name, rises, steps_left, exp_left_q[rises-1]);
                end
                last_rise = c;
            end
            if (step_pulse === 1'b1) begin
                hi_len++;
            end else if (prev) begin
                checks++;
                if (hi_len != PW) begin
                    errors++;
                    $display("FAIL %s pulse_width got %0d want %0d", name, hi_len, PW);
                end
                hi_len = 0;
            end
            prev = (step_pulse === 1'b1);
            abort = (abort_at > 0) && (rises == abort_at) && (done_c < 0);
            if (noise && done_c < 0) begin
                cmd_valid  = 1'($urandom_range(0, 1));
                cmd_period = $urandom;
            end else begin
                cmd_valid = 1'b0;
            end
            if (done_c < 0) begin
                @(negedge clk);
                c++;
            end
        end
        abort = 1'b0;
        cmd_valid = 1'b0;

        checks++;
        if (done_c < 0) begin
            errors++;
            $display("FAIL %s done_timeout got none want done within %0d", name, MAX_CYC);
        end else begin
            checks++;
            if (done_c != total) begin
                errors++;
                $display("FAIL %s done_time got %0d want %0d", name, done_c, total);
            end
            checks++;
            if (rises != exp_period_q.size()) begin
                errors++;
                $display("FAIL %s step_count got %0d want %0d", name, rises, exp_period_q.size());
            end
            checks++;
            if (busy !== 1'b0 || steps_left !== exp_final_left) begin
                errors++;
                $display("FAIL %s at_done got busy=%b left=%0d want 0 %0d",
                         name, busy, steps_left, exp_final_left);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || cmd_ready !== 1'b1 || dir_out !== d || state_dbg !== ST_IDLE) begin
                errors++;
                $display("FAIL %s after_done got done=%b ready=%b dir=%b st=%0d want 0 1 %b 0",
                         name, done, cmd_ready, dir_out, state_dbg, d);
            end
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (cmd_ready !== 1'b1 || step_pulse !== 1'b0 || dir_out !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || steps_left !== '0 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL %s got rdy=%b stp=%b dir=%b busy=%b done=%b left=%0d st=%0d want 1 0 0 0 0 0 0",
                     name, cmd_ready, step_pulse, dir_out, busy, done, steps_left, state_dbg);
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset_pwrup");
        resetb = 1'b1;
    endtask

    task automatic test_ramp_profile();
        run_move("ramp10", 10, 12, 1'b1, 0, 1'b0);
    endtask

    task automatic test_short_move();
        run_move("ramp6", 6, 8, 1'b0, 0, 1'b0);
    endtask

    task automatic test_zero_steps();
        run_move("zero", 0, 12, 1'b1, 0, 1'b0);
    endtask

    task automatic test_clamp();
        run_move("clamp_lo", 12, 1, 1'b0, 0, 1'b0);
        run_move("clamp_hi", 4, 50, 1'b1, 0, 1'b0);
    endtask

    task automatic test_abort();
        run_move("abort3", 10, 12, 1'b1, 3, 1'b0);
    endtask

    task automatic test_reset_mid_move();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_steps = 16'd10; cmd_dir = 1'b1; cmd_period = 32'd12;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_mid");
        for (int i = 0; i < 6; i++) begin
            if (i == 1) resetb = 1'b1;
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || cmd_ready !== 1'b1 || step_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet c=%0d got done=%b rdy=%b stp=%b want 0 1 0",
                         i, done, cmd_ready, step_pulse);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, raw, ab;
        for (int i = 0; i < 25; i++) begin
            n   = $urandom_range(0, 12);
            raw = $urandom_range(0, 30);
            ab  = ($urandom_range(0, 2) == 0 && n > 0) ? $urandom_range(1, n) : 0;
            run_move("random", n, raw, 1'($urandom_range(0, 1)), ab, 1'b1);
        end
    endtask

    initial begin
        resetb = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0;
        cmd_period = '0; abort = 1'b0;
        test_reset();
        test_ramp_profile();
        test_short_move();
        test_zero_steps();
        test_clamp();
        test_abort();
        test_reset_mid_move();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stepper_move_scheduler.md
Name: stepper_move_scheduler

Overview:
- Sequences one stepper move at a time: accepts a move command (step count, direction, target step period) over a valid/ready handshake.
- Generates step/dir pulses with a linear period ramp: accelerate from START_PERIOD down to the target period, cruise, then decelerate symmetrically before the last step.
- Sits between the speed-selection logic, which supplies the target period in clk cycles, and the motor driver pins.

Parameters:
- START_PERIOD, 1515151, slowest step period in clk cycles; every move starts here and ramps back toward it.
- RAMP_DEC, 50000, period change in clk cycles applied per step boundary while ramping.
- PULSE_W, 100, step_pulse high time in clk cycles.
- STEP_W, 16, width of the step-count fields.

Ports:
- clk  in  1  system clock
- resetb  in  1  synchronous active-low reset
- cmd_valid  in  1  move command valid
- cmd_ready  out  1  scheduler can accept a command (high only in IDLE)
- cmd_steps  in  STEP_W  number of steps to issue
- cmd_dir  in  1  direction for this move
- cmd_period  in  32  target cruise period in clk cycles
- abort  in  1  level request to stop the current move
- step_pulse  out  1  step output to driver
- dir_out  out  1  direction output to driver
- busy  out  1  move in progress
- done  out  1  single-cycle pulse at move end
- steps_left  out  STEP_W  steps remaining in the current move

Behaviour:
- Reset (resetb low at a clk edge): state IDLE; cmd_ready=1; step_pulse=0, dir_out=0, busy=0, done=0, steps_left=0; all internal counters 0.
- Reset mid-move aborts the move instantly with no done pulse.
- States: IDLE, ACCEL, CRUISE, DECEL, DONE.
- Command acceptance:
  - A command is accepted at edge T when cmd_valid && cmd_ready.
  - On acceptance, latch cmd_dir into dir_out, cmd_steps into steps_left, and the clamped target.
  - Target clamp: min(max(cmd_period, 2*PULSE_W), START_PERIOD).
  - Set cur_period=START_PERIOD, accel_cnt=0, period counter=0, busy=1.
- Next state after acceptance:
  - cmd_steps==0: DONE.
  - Clamped target==START_PERIOD: CRUISE.
  - Otherwise: ACCEL.
- First step_pulse rises at T+1.
- Period counter runs 0..cur_period-1. step_pulse=1 while counter<PULSE_W.
- Step boundary is the cycle where counter==cur_period-1. At each boundary, left'=steps_left-1 is written to steps_left, then the first matching rule applies:
  1. left'==0: go to DONE.
  2. left'<=accel_cnt: go to DECEL; cur_period=min(cur_period+RAMP_DEC, START_PERIOD); accel_cnt decrements (saturates at 0).
  3. In ACCEL: cur_period=max(cur_period-RAMP_DEC, target); accel_cnt increments; if the new cur_period==target, go to CRUISE.
  4. In CRUISE or DECEL: cur_period unchanged (DECEL stays in DECEL under rule 2).
- DONE state: lasts one cycle with done=1; busy drops to 0 in the same cycle; returns to IDLE. dir_out holds its value until the next acceptance.
- cmd_period changes during a move are ignored; the target is sampled only at acceptance.
- abort is sampled only at step boundaries and ignored in IDLE/DONE. An in-progress pulse is never truncated.
- cmd_valid while busy is held off by cmd_ready=0; no queueing.

Optional Feature:
- Macro: SOFT_ABORT_EN.
- Defined: abort at a boundary sets steps_left=min(left', accel_cnt) and enters DECEL, so the motor ramps down; if that value is 0, go to DONE.
- Undefined: abort at a boundary goes directly to DONE; steps_left shows the untaken steps (left').

Test Plan:
- Bench params for all cases: START_PERIOD=20, RAMP_DEC=4, PULSE_W=2.
- Reset: hold resetb low 3 cycles mid-move -> all outputs at reset values next edge; cmd_ready=1; no done pulse.
- cmd_steps=10, cmd_period=12 -> step periods 20,16,12,12,12,12,12,12,16,20 (144 cycles); each pulse 2 cycles wide; done one cycle after the last period; busy low in the same cycle as done.
- cmd_steps=6, cmd_period=8 -> periods 20,16,12,8,12,16; steps_left counts 5..0.
- cmd_steps=0 -> accepted; done at T+1; no step_pulse.
- cmd_period=1 -> clamped to 4. cmd_period=50 -> clamped to 20; all periods 20; state goes straight to CRUISE.
- cmd_steps=10, cmd_period=12, abort asserted during step 3:
  - SOFT_ABORT_EN undefined: done after step 3; steps_left=7.
  - SOFT_ABORT_EN defined: periods 20,16,12,16,20, then done.
